frame_sequencer: RTL and testbench

Top-level scheduler for the GPU triangle pipeline. It accepts triangles from upstream and starts the rasterizer, and it owns the flip strobes of the wireframe and frame-buffer double SRAMs. It launches all colour-fill modules together and joins their done pulses, then hands each finished frame to the frame-buffer transfer block. Three cooperating FSMs (raster, fill, transfer) overlap work: the rasterizer can run ahead on the next triangle while the fill modules work, and the fill modules can work while the previous frame transfers.

---
 rtl/frame_sequencer.sv | 119 +++++++++++
 tb/tb_frame_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_sequencer.sv
// Triangle-pipeline scheduler: raster, fill and transfer FSMs run overlapped and
// hand work forward through the wireframe and frame-buffer double buffers.
module frame_sequencer #(
  parameter int NUM_CF_MODS = 4,
  parameter int CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tri_valid,
  input  logic                   tri_last,
  output logic                   tri_accept,
  output logic                   ras_start,
  input  logic                   ras_done,
  output logic                   wf_flip,
  output logic                   cf_start,
  input  logic [NUM_CF_MODS-1:0] cf_done,
  output logic                   fb_flip,
  output logic                   fbt_start,
  input  logic                   fbt_done,
  output logic                   busy,
  output logic [CNT_W-1:0]       tri_count,
  output logic [CNT_W-1:0]       frame_count
);

  typedef enum logic [1:0] {R_IDLE, R_RUN, R_WAIT} raster_state_e;
  typedef enum logic [1:0] {F_IDLE, F_START, F_RUN, F_WAIT_FB} fill_state_e;
  typedef enum logic [1:0] {T_IDLE, T_START, T_RUN} xfer_state_e;

  raster_state_e          r_state, r_next;
  fill_state_e            f_state, f_next;
  xfer_state_e            t_state, t_next;
  logic                   r_last, f_last;
  logic [NUM_CF_MODS-1:0] cf_latch;
  logic                   accept, wf_go, cf_all, fill_done, fb_go, fbt_fin;

  // Hand-off decisions look at the neighbouring FSM's current state, so a
  // handover takes effect on the same edge in both FSMs.
  always_comb begin
    accept    = (r_state == R_IDLE) && tri_valid;
    wf_go     = (f_state == F_IDLE) &&
                (((r_state == R_RUN) && ras_done) || (r_state == R_WAIT));
    cf_all    = &(cf_latch | cf_done);
    fill_done = (f_state == F_RUN) && cf_all;
    fb_go     = (f_state == F_WAIT_FB) && (t_state == T_IDLE);
    fbt_fin   = (t_state == T_RUN) && fbt_done;
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (accept) r_next = R_RUN;
      R_RUN:   if (ras_done) r_next = wf_go ? R_IDLE : R_WAIT;
      R_WAIT:  if (wf_go) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase

    f_next = f_state;
    case (f_state)
      F_IDLE:    if (wf_go) f_next = F_START;
      F_START:   f_next = F_RUN;
      F_RUN:     if (cf_all) f_next = f_last ? F_WAIT_FB : F_IDLE;
      F_WAIT_FB: if (fb_go) f_next = F_IDLE;
      default:   f_next = F_IDLE;
    endcase

    t_next = t_state;
    case (t_state)
      T_IDLE:  if (fb_go) t_next = T_START;
      T_START: t_next = T_RUN;
      T_RUN:   if (fbt_done) t_next = T_IDLE;
      default: t_next = T_IDLE;
    endcase
  end

  // Outputs are registered from the same decisions that advance the states,
  // so busy tracks the state each FSM is entering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= R_IDLE;
      f_state     <= F_IDLE;
      t_state     <= T_IDLE;
      r_last      <= 1'b0;
      f_last      <= 1'b0;
      cf_latch    <= '0;
      tri_accept  <= 1'b0;
      ras_start   <= 1'b0;
      wf_flip     <= 1'b0;
      cf_start    <= 1'b0;
      fb_flip     <= 1'b0;
      fbt_start   <= 1'b0;
      busy        <= 1'b0;
      tri_count   <= '0;
      frame_count <= '0;
    end else begin
      r_state    <= r_next;
      f_state    <= f_next;
      t_state    <= t_next;
      tri_accept <= accept;
      ras_start  <= accept;
      wf_flip    <= wf_go;
      cf_start   <= (f_state == F_START);
      fb_flip    <= fb_go;
      fbt_start  <= (t_state == T_START);
      busy       <= (r_next != R_IDLE) || (f_next != F_IDLE) || (t_next != T_IDLE);

      if (accept) r_last <= tri_last;
      if (wf_go) f_last <= r_last;

      if (f_state == F_START) cf_latch <= '0;
      else if (f_state == F_RUN) cf_latch <= cf_latch | cf_done;

      if (fill_done) tri_count <= tri_count + CNT_W'(1);
      else if (fb_go) tri_count <= '0;

      if (fbt_fin) frame_count <= frame_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer: behavioural rasterizer, fill and transfer
// responders with programmable latencies; a monitor timestamps every output pulse.
module tb_frame_sequencer;

  localparam int NCF = 4;
  localparam int CW  = 16;

  logic           clk, rst, tri_valid, tri_last, ras_done, fbt_done;
  logic [NCF-1:0] cf_done;
  logic           tri_accept, ras_start, wf_flip, cf_start, fb_flip, fbt_start, busy;
  logic [CW-1:0]  tri_count, frame_count;

  logic           m_ras_done, r_ras_done, m_fbt_done, r_fbt_done;
  logic [NCF-1:0] m_cf_done, r_cf_done;
  assign ras_done = m_ras_done | r_ras_done;
  assign fbt_done = m_fbt_done | r_fbt_done;
  assign cf_done  = m_cf_done | r_cf_done;

  int ras_delay, fbt_delay, cf_rep0;
  int cf_off [NCF];
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  logic cnt_clr;

  int n_acc, n_ras, n_wf, n_cf, n_fb, n_fbt, tc_max, t_busy_fall, t_tc_up;
  int ras_t [8];
  int wf_t  [8];
  int cf_t  [8];
  int fb_t  [8];
  int fbt_t [8];
  int fc_at_fb [8];
  logic          busy_q;
  logic [CW-1:0] tc_q;

  frame_sequencer #(.NUM_CF_MODS(NCF), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .tri_valid(tri_valid), .tri_last(tri_last),
    .tri_accept(tri_accept), .ras_start(ras_start), .ras_done(ras_done),
    .wf_flip(wf_flip), .cf_start(cf_start), .cf_done(cf_done),
    .fb_flip(fb_flip), .fbt_start(fbt_start), .fbt_done(fbt_done),
    .busy(busy), .tri_count(tri_count), .frame_count(frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse counts and timestamps are taken on the falling edge, clear of the active edge.
  always @(negedge clk) begin
    busy_q <= busy;
    tc_q   <= tri_count;
    if (cnt_clr) begin
      n_acc <= 0; n_ras <= 0; n_wf <= 0; n_cf <= 0; n_fb <= 0; n_fbt <= 0;
      tc_max <= 0; t_busy_fall <= -1; t_tc_up <= -1;
    end else begin
      if (tri_accept) n_acc <= n_acc + 1;
      if (ras_start) begin
        if (n_ras < 8) ras_t[n_ras] <= cyc;
        n_ras <= n_ras + 1;
      end
      if (wf_flip) begin
        if (n_wf < 8) wf_t[n_wf] <= cyc;
        n_wf <= n_wf + 1;
      end
      if (cf_start) begin
        if (n_cf < 8) cf_t[n_cf] <= cyc;
        n_cf <= n_cf + 1;
      end
      if (fb_flip) begin
        if (n_fb < 8) begin
          fb_t[n_fb]     <= cyc;
          fc_at_fb[n_fb] <= int'(frame_count);
        end
        n_fb <= n_fb + 1;
      end
      if (fbt_start) begin
        if (n_fbt < 8) fbt_t[n_fbt] <= cyc;
        n_fbt <= n_fbt + 1;
      end
      if (int'(tri_count) > tc_max) tc_max <= int'(tri_count);
      if (busy_q && !busy) t_busy_fall <= cyc;
      if ((tri_count > tc_q) && (t_tc_up < 0)) t_tc_up <= cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int observed, input int expected);
    n_checks++;
    if (observed == expected) n_pass++;
    else $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic valid, input logic last);
    tri_valid = valid;
    tri_last  = last;
  endtask

  function automatic logic probe(input int sel);
    case (sel)
      0:       return tri_accept;
      1:       return cf_start;
      default: return !busy;
    endcase
  endfunction

  task automatic waitSig(input int sel, input int budget, input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      tick();
      found = probe(sel);
    end
    checkOutput(tag, int'(found), 1);
  endtask

  task automatic clearCounts();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    clearCounts();
  endtask

  task automatic setTiming(input int rd, input int o0, input int o1, input int o2,
                           input int o3, input int rep, input int fd);
    ras_delay = rd;
    cf_off[0] = o0; cf_off[1] = o1; cf_off[2] = o2; cf_off[3] = o3;
    cf_rep0   = rep;
    fbt_delay = fd;
  endtask

  // Rasterizer model: ras_done sampled ras_delay edges after ras_start's edge.
  initial begin
    r_ras_done = 1'b0;
    forever begin
      tick();
      if (ras_start && !rst) begin
        for (int i = 1; i < ras_delay && !rst; i++) tick();
        r_ras_done = !rst;
        tick();
        r_ras_done = 1'b0;
      end
    end
  end

  // Fill-module model: module m pulses done at offset cf_off[m]; module 0 may repeat.
  initial begin
    r_cf_done = '0;
    forever begin
      tick();
      if (cf_start && !rst) begin
        int mx;
        mx = cf_rep0;
        for (int m = 0; m < NCF; m++) if (cf_off[m] > mx) mx = cf_off[m];
        for (int t = 1; t <= mx && !rst; t++) begin
          for (int m = 0; m < NCF; m++)
            r_cf_done[m] = (cf_off[m] == t) || ((m == 0) && (cf_rep0 == t));
          tick();
          r_cf_done = '0;
        end
      end
    end
  end

  initial begin
    r_fbt_done = 1'b0;
    forever begin
      tick();
      if (fbt_start && !rst) begin
        for (int i = 1; i < fbt_delay && !rst; i++) tick();
        r_fbt_done = !rst;
        tick();
        r_fbt_done = 1'b0;
      end
    end
  end

  task automatic runSingleFrame(input string tag);
    setTiming(5, 2, 4, 4, 9, 0, 20);
    clearCounts();
    applyStimulus(1'b1, 1'b1);
    waitSig(0, 50, {tag, " accept"});
    checkOutput({tag, " busy rises"}, int'(busy), 1);
    applyStimulus(1'b0, 1'b0);
    waitSig(2, 300, {tag, " idle"});
    repeat (3) tick();
    checkOutput({tag, " n_accept"}, n_acc, 1);
    checkOutput({tag, " n_wf_flip"}, n_wf, 1);
    checkOutput({tag, " n_cf_start"}, n_cf, 1);
    checkOutput({tag, " n_fb_flip"}, n_fb, 1);
    checkOutput({tag, " n_fbt_start"}, n_fbt, 1);
    checkOutput({tag, " ras->wf"}, wf_t[0] - ras_t[0], 5);
    checkOutput({tag, " wf->cf"}, cf_t[0] - wf_t[0], 1);
    checkOutput({tag, " cf->fill done"}, t_tc_up - cf_t[0], 9);
    checkOutput({tag, " cf->fb"}, fb_t[0] - cf_t[0], 10);
    checkOutput({tag, " fb->fbt"}, fbt_t[0] - fb_t[0], 1);
    checkOutput({tag, " fbt->busy fall"}, t_busy_fall - fbt_t[0], 20);
    checkOutput({tag, " tri_count peak"}, tc_max, 1);
    checkOutput({tag, " tri_count"}, int'(tri_count), 0);
    checkOutput({tag, " frame_count"}, int'(frame_count), 1);
  endtask

  initial begin
    rst = 1'b1; cnt_clr = 1'b1;
    applyStimulus(1'b0, 1'b0);
    m_ras_done = 1'b0; m_fbt_done = 1'b0; m_cf_done = '0;
    setTiming(5, 2, 4, 4, 9, 0, 20);
    tick();
    tick();
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset tri_count", int'(tri_count), 0);
    checkOutput("reset frame_count", int'(frame_count), 0);
    checkOutput("reset pulses", int'({tri_accept, ras_start, wf_flip, cf_start, fb_flip, fbt_start}), 0);
    rst = 1'b0;
    tick();

    runSingleFrame("single");

    // Staggered join on a non-last triangle: only module 3 at offset 30 completes it.
    doReset();
    setTiming(3, 1, 3, 7, 30, 5, 5);
    applyStimulus(1'b1, 1'b0);
    waitSig(0, 50, "stag accept");
    applyStimulus(1'b0, 1'b0);
    waitSig(2, 200, "stag idle");
    repeat (3) tick();
    checkOutput("stag n_cf_start", n_cf, 1);
    checkOutput("stag join time", t_tc_up - cf_t[0], 30);
    checkOutput("stag tri_count", int'(tri_count), 1);
    checkOutput("stag n_fb_flip", n_fb, 0);
    checkOutput("stag frame_count", int'(frame_count), 0);

    // Overlap: raster 10 cycles, fill 40 cycles, three triangles held back-to-back.
    doReset();
    setTiming(10, 10, 20, 30, 40, 0, 5);
    applyStimulus(1'b1, 1'b0);
    waitSig(0, 50, "ovl accept1");
    waitSig(0, 50, "ovl accept2");
    applyStimulus(1'b1, 1'b1);
    waitSig(0, 100, "ovl accept3");
    applyStimulus(1'b0, 1'b0);
    waitSig(2, 400, "ovl idle");
    repeat (3) tick();
    checkOutput("ovl ras2 time", ras_t[1] - ras_t[0], 11);
    checkOutput("ovl ras3 time", ras_t[2] - ras_t[0], 53);
    checkOutput("ovl wf2 after fill1", wf_t[1] - cf_t[0], 41);
    checkOutput("ovl wf3 time", wf_t[2] - wf_t[0], 84);
    checkOutput("ovl fb time", fb_t[0] - wf_t[0], 126);
    checkOutput("ovl n_cf_start", n_cf, 3);
    checkOutput("ovl n_fb_flip", n_fb, 1);
    checkOutput("ovl tri_count peak", tc_max, 3);
    checkOutput("ovl tri_count", int'(tri_count), 0);
    checkOutput("ovl frame_count", int'(frame_count), 1);

    // Spurious done pulses while every FSM is idle.
    doReset();
    m_ras_done = 1'b1; m_cf_done = '1; m_fbt_done = 1'b1;
    tick();
    m_ras_done = 1'b0; m_cf_done = '0; m_fbt_done = 1'b0;
    tick();
    m_cf_done = 4'b0101;
    tick();
    m_cf_done = '0;
    repeat (5) tick();
    checkOutput("spur n_pulses", n_acc + n_ras + n_wf + n_cf + n_fb + n_fbt, 0);
    checkOutput("spur busy", int'(busy), 0);
    checkOutput("spur tri_count", int'(tri_count), 0);
    checkOutput("spur frame_count", int'(frame_count), 0);

    // Transfer back-pressure: two one-triangle frames, transfer takes 100 cycles.
    doReset();
    setTiming(3, 1, 1, 1, 1, 0, 100);
    applyStimulus(1'b1, 1'b1);
    waitSig(0, 50, "bp accept1");
    waitSig(0, 50, "bp accept2");
    applyStimulus(1'b0, 1'b0);
    waitSig(2, 600, "bp idle");
    repeat (3) tick();
    checkOutput("bp n_fb_flip", n_fb, 2);
    checkOutput("bp wf2 time", wf_t[1] - wf_t[0], 4);
    checkOutput("bp fb2 held", fb_t[1] - fbt_t[0], 101);
    checkOutput("bp frames at fb1", fc_at_fb[0], 0);
    checkOutput("bp frames at fb2", fc_at_fb[1], 1);
    checkOutput("bp frame_count", int'(frame_count), 2);

    // Reset mid-fill with two of four modules latched, then a clean frame.
    setTiming(5, 2, 4, 20, 25, 0, 20);
    clearCounts();
    applyStimulus(1'b1, 1'b1);
    waitSig(0, 50, "rst accept");
    applyStimulus(1'b0, 1'b0);
    waitSig(1, 50, "rst cf_start");
    repeat (5) tick();
    checkOutput("rst busy before", int'(busy), 1);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("rst busy", int'(busy), 0);
    checkOutput("rst tri_count", int'(tri_count), 0);
    checkOutput("rst frame_count", int'(frame_count), 0);
    checkOutput("rst pulses", int'({tri_accept, ras_start, wf_flip, cf_start, fb_flip, fbt_start}), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (30) tick();
    runSingleFrame("post-reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
